// File: rtl/block_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : block_mem_bridge_pkg
// Purpose  : Shared constants, state encoding and address helper for the
//            block-to-beat memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package block_mem_bridge_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_DATA_WIDTH = 512;
    localparam int BEATS            = BLOCK_DATA_WIDTH / WORD_SIZE;
    localparam int BEAT_BITS        = 4;
    localparam int BLOCK_BYTE_BITS  = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WDATA   = 3'd2,
        RDATA   = 3'd3,
        DONE    = 3'd4,
        RELEASE = 3'd5
    } state_t;

    // Clear the byte-offset bits so the bus always sees a block base address.
    function automatic logic [WORD_SIZE-1:0] align_block(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:BLOCK_BYTE_BITS], {BLOCK_BYTE_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_mem_bridge_beat_buffer.sv
`default_nettype none
// ============================================================================
// Module   : block_beat_buffer
// Purpose  : One cache block of storage with whole-block load, single-word
//            write and single-word read, all addressed by beat index.
//            data_next exposes the value the register takes on the next edge
//            so the parent can snapshot a block in the same cycle the last
//            word lands.
// Revision : 1.0 - initial release
// ============================================================================
module block_beat_buffer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 512,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WORD_W-1:0]  wr_word,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [WORD_W-1:0]  rd_word,
    output logic [BLOCK_W-1:0] data_next
);

    logic [BLOCK_W-1:0] r_data;
    logic [BLOCK_W-1:0] w_next;

    // Next block value: a full load takes priority over a word write.
    always_comb begin
        w_next = r_data;
        if (load) begin
            w_next = load_data;
        end else if (wr_en) begin
            w_next[int'(wr_idx) * WORD_W +: WORD_W] = wr_word;
        end
    end

    // Block storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    assign rd_word   = r_data[int'(rd_idx) * WORD_W +: WORD_W];
    assign data_next = w_next;

endmodule
`default_nettype wire

// File: rtl/block_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : block_mem_bridge
// Purpose  : Turns one 512-bit block request from the cache controller into a
//            single bus command followed by 16 ascending 32-bit beats, then
//            returns the assembled block with a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module block_mem_bridge
    import block_mem_bridge_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_enable,
    input  logic                        mem_req_rw,
    input  logic [WORD_SIZE-1:0]        mem_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        mem_req_ready,
    output logic                        bus_cmd_valid,
    input  logic                        bus_cmd_ready,
    output logic                        bus_cmd_rw,
    output logic [WORD_SIZE-1:0]        bus_cmd_addr,
    output logic                        bus_wdata_valid,
    input  logic                        bus_wdata_ready,
    output logic [WORD_SIZE-1:0]        bus_wdata,
    output logic                        bus_wlast,
    input  logic                        bus_rdata_valid,
    output logic                        bus_rdata_ready,
    input  logic [WORD_SIZE-1:0]        bus_rdata,
    output logic                        busy
);

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_rw;
    logic [WORD_SIZE-1:0]        r_addr;
    logic [BEAT_BITS-1:0]        r_beat_cnt;
    logic [BLOCK_DATA_WIDTH-1:0] r_datain;

    logic                        w_capture;
    logic                        w_cmd_fire;
    logic                        w_wbeat_fire;
    logic                        w_rbeat_fire;
    logic                        w_last_beat;
    logic [WORD_SIZE-1:0]        w_buf_word;
    logic [BLOCK_DATA_WIDTH-1:0] w_buf_next;

    assign w_capture    = (r_state == IDLE)  && mem_req_enable;
    assign w_cmd_fire   = (r_state == CMD)   && bus_cmd_ready;
    assign w_wbeat_fire = (r_state == WDATA) && bus_wdata_ready;
    assign w_rbeat_fire = (r_state == RDATA) && bus_rdata_valid;
    assign w_last_beat  = (r_beat_cnt == BEAT_BITS'(BEATS - 1));

    block_beat_buffer #(
        .WORD_W  (WORD_SIZE),
        .BLOCK_W (BLOCK_DATA_WIDTH),
        .IDX_W   (BEAT_BITS)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_capture && mem_req_rw),
        .load_data (mem_req_dataout),
        .wr_en     (w_rbeat_fire),
        .wr_idx    (r_beat_cnt),
        .wr_word   (bus_rdata),
        .rd_idx    (r_beat_cnt),
        .rd_word   (w_buf_word),
        .data_next (w_buf_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture: direction and block base are frozen until back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw   <= 1'b0;
            r_addr <= '0;
        end else if (w_capture) begin
            r_rw   <= mem_req_rw;
            r_addr <= align_block(mem_req_addr);
        end
    end

    // Beat counter: cleared on command accept, advanced per accepted beat;
    // the natural 15->0 wrap coincides with leaving the data state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_cmd_fire) begin
            r_beat_cnt <= '0;
        end else if (w_wbeat_fire || w_rbeat_fire) begin
            r_beat_cnt <= r_beat_cnt + BEAT_BITS'(1);
        end
    end

    // Returned block: snapshot taken as the final beat completes, so it is
    // valid during DONE and held until the next transfer finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_datain <= '0;
        end else if ((w_wbeat_fire || w_rbeat_fire) && w_last_beat) begin
            r_datain <= w_buf_next;
        end
    end

    // Next-state and bus strobes.
    always_comb begin
        w_state_next    = r_state;
        bus_cmd_valid   = 1'b0;
        bus_wdata_valid = 1'b0;
        bus_wlast       = 1'b0;
        bus_rdata_ready = 1'b0;
        mem_req_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req_enable) begin
                    w_state_next = CMD;
                end
            end
            CMD: begin
                bus_cmd_valid = 1'b1;
                if (bus_cmd_ready) begin
                    w_state_next = r_rw ? WDATA : RDATA;
                end
            end
            WDATA: begin
                bus_wdata_valid = 1'b1;
                bus_wlast       = w_last_beat;
                if (bus_wdata_ready && w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            RDATA: begin
                bus_rdata_ready = 1'b1;
                if (bus_rdata_valid && w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                mem_req_ready = 1'b1;
                w_state_next  = RELEASE;
            end
            RELEASE: begin
                if (!mem_req_enable) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus_cmd_rw     = r_rw;
    assign bus_cmd_addr   = r_addr;
    assign bus_wdata      = w_buf_word;
    assign mem_req_datain = r_datain;
    assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire
